// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request, response and memory-side signals around the data memory arbiter
interface dmem_arbiter_if #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 13
);
    logic                        pipe_req;
    logic                        pipe_we;
    logic [MEMORY_ADDR_SIZE-1:0] pipe_addr;
    logic [ARQ-1:0]              pipe_wdata;
    logic                        pipe_stall;
    logic                        pipe_rvalid;
    logic [ARQ-1:0]              pipe_rdata;

    logic                        ldr_req;
    logic                        ldr_we;
    logic [MEMORY_ADDR_SIZE-1:0] ldr_addr;
    logic [ARQ-1:0]              ldr_wdata;
    logic                        ldr_lock;
    logic                        ldr_gnt;
    logic                        ldr_rvalid;
    logic [ARQ-1:0]              ldr_rdata;
    logic                        ldr_locked;

    logic                        mem_en;
    logic                        mem_we;
    logic [MEMORY_ADDR_SIZE-1:0] mem_addr;
    logic [ARQ-1:0]              mem_wdata;
    logic [ARQ-1:0]              mem_rdata;

    modport slave (
        input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
        output pipe_stall, pipe_rvalid, pipe_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output ldr_gnt, ldr_rvalid, ldr_rdata, ldr_locked,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output pipe_req, pipe_we, pipe_addr, pipe_wdata,
        input  pipe_stall, pipe_rvalid, pipe_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  ldr_gnt, ldr_rvalid, ldr_rdata, ldr_locked,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter between MEM stage and key loader
module dmem_arbiter #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 13,
    parameter int STARVE_LIMIT     = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic {ST_SHARED, ST_LOCKED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_LDR} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t         state_q, state_d;
    owner_t         rd_owner_q, rd_owner_d;
    logic [3:0]     starve_q, starve_d;
    logic [ARQ-1:0] pipe_hold_q, pipe_hold_d;
    logic [ARQ-1:0] ldr_hold_q, ldr_hold_d;
    logic           pipe_gnt, ldr_gnt;

    always_comb begin
        state_d    = state_q;
        pipe_gnt   = 1'b0;
        ldr_gnt    = 1'b0;
        starve_d   = 4'd0;
        rd_owner_d = OWN_NONE;
        case (state_q)
            ST_SHARED: begin
                // A starved loader overrides pipeline priority for one cycle
                if (bus.ldr_req && starve_q == LIMIT) begin
                    ldr_gnt = 1'b1;
                end else if (bus.pipe_req) begin
                    pipe_gnt = 1'b1;
                end else begin
                    ldr_gnt = bus.ldr_req;
                end
                if (bus.ldr_req && !ldr_gnt) begin
                    starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
                end
                if (bus.ldr_lock) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                ldr_gnt = bus.ldr_req;
                if (!bus.ldr_lock) begin
                    state_d = ST_SHARED;
                end
            end
            default: state_d = ST_SHARED;
        endcase
        if (pipe_gnt && !bus.pipe_we) begin
            rd_owner_d = OWN_PIPE;
        end else if (ldr_gnt && !bus.ldr_we) begin
            rd_owner_d = OWN_LDR;
        end
    end

    always_comb begin
        bus.mem_en    = pipe_gnt | ldr_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (pipe_gnt) begin
            bus.mem_we    = bus.pipe_we;
            bus.mem_addr  = bus.pipe_addr;
            bus.mem_wdata = bus.pipe_wdata;
        end else if (ldr_gnt) begin
            bus.mem_we    = bus.ldr_we;
            bus.mem_addr  = bus.ldr_addr;
            bus.mem_wdata = bus.ldr_wdata;
        end
    end

    assign bus.pipe_stall  = bus.pipe_req & ~pipe_gnt;
    assign bus.ldr_gnt     = ldr_gnt;
    assign bus.ldr_locked  = (state_q == ST_LOCKED);

    // Read data is routed by the owner latched at grant time, one cycle earlier
    assign bus.pipe_rvalid = (rd_owner_q == OWN_PIPE);
    assign bus.ldr_rvalid  = (rd_owner_q == OWN_LDR);
    assign bus.pipe_rdata  = bus.pipe_rvalid ? bus.mem_rdata : pipe_hold_q;
    assign bus.ldr_rdata   = bus.ldr_rvalid  ? bus.mem_rdata : ldr_hold_q;
    assign pipe_hold_d     = bus.pipe_rdata;
    assign ldr_hold_d      = bus.ldr_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SHARED;
            rd_owner_q  <= OWN_NONE;
            starve_q    <= 4'd0;
            pipe_hold_q <= '0;
            ldr_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_owner_q  <= rd_owner_d;
            starve_q    <= starve_d;
            pipe_hold_q <= pipe_hold_d;
            ldr_hold_q  <= ldr_hold_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam int ARQ   = 16;
    localparam int AW    = 13;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(AW)) bus ();

    dmem_arbiter #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory environment: registered read, one-cycle latency
    logic [ARQ-1:0] mem_arr [0:(1<<AW)-1];
    logic [ARQ-1:0] mem_rdata_r = '0;
    assign bus.mem_rdata = mem_rdata_r;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
            else            mem_rdata_r <= mem_arr[bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference state
    bit             m_locked;
    int             m_starve;
    int             m_pend;        // 0 none, 1 pipeline, 2 loader
    logic [ARQ-1:0] m_pend_data;
    logic [ARQ-1:0] m_phold, m_lhold;
    logic [ARQ-1:0] shadow [0:(1<<AW)-1];

    task automatic model_reset();
        m_locked = 0; m_starve = 0; m_pend = 0;
        m_pend_data = '0; m_phold = '0; m_lhold = '0;
    endtask

    task automatic drive_idle();
        bus.pipe_req = 0; bus.pipe_we = 0; bus.pipe_addr = '0; bus.pipe_wdata = '0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        bus.ldr_lock = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"},   32'(bus.pipe_stall), 0);
        chk({tag, "_gnt"},     32'(bus.ldr_gnt), 0);
        chk({tag, "_mem_en"},  32'(bus.mem_en), 0);
        chk({tag, "_addr"},    32'(bus.mem_addr), 0);
        chk({tag, "_wdata"},   32'(bus.mem_wdata), 0);
        chk({tag, "_prvalid"}, 32'(bus.pipe_rvalid), 0);
        chk({tag, "_lrvalid"}, 32'(bus.ldr_rvalid), 0);
        chk({tag, "_prdata"},  32'(bus.pipe_rdata), 0);
        chk({tag, "_lrdata"},  32'(bus.ldr_rdata), 0);
        chk({tag, "_locked"},  32'(bus.ldr_locked), 0);
    endtask

    task automatic cycle(input bit preq, input bit pwe, input logic [AW-1:0] pa, input logic [ARQ-1:0] pd,
                         input bit lreq, input bit lwe, input logic [AW-1:0] la, input logic [ARQ-1:0] ld,
                         input bit lock);
        bit pg, lg, e_we;
        logic [AW-1:0]  e_addr;
        logic [ARQ-1:0] e_wdata, e_prdata, e_lrdata;
        @(negedge clk);
        bus.pipe_req = preq; bus.pipe_we = pwe; bus.pipe_addr = pa; bus.pipe_wdata = pd;
        bus.ldr_req = lreq; bus.ldr_we = lwe; bus.ldr_addr = la; bus.ldr_wdata = ld;
        bus.ldr_lock = lock;
        #1;
        pg = 0; lg = 0;
        if (m_locked)                        lg = lreq;
        else if (lreq && m_starve == LIMIT)  lg = 1;
        else if (preq)                       pg = 1;
        else                                 lg = lreq;
        e_we    = pg ? pwe : (lg ? lwe : 1'b0);
        e_addr  = pg ? pa  : (lg ? la  : '0);
        e_wdata = pg ? pd  : (lg ? ld  : '0);
        e_prdata = (m_pend == 1) ? m_pend_data : m_phold;
        e_lrdata = (m_pend == 2) ? m_pend_data : m_lhold;
        chk("pipe_stall",  32'(bus.pipe_stall), 32'(preq && !pg));
        chk("ldr_gnt",     32'(bus.ldr_gnt), 32'(lg));
        chk("mem_en",      32'(bus.mem_en), 32'(pg || lg));
        chk("mem_we",      32'(bus.mem_we), 32'(e_we));
        chk("mem_addr",    32'(bus.mem_addr), 32'(e_addr));
        chk("mem_wdata",   32'(bus.mem_wdata), 32'(e_wdata));
        chk("pipe_rvalid", 32'(bus.pipe_rvalid), 32'(m_pend == 1));
        chk("ldr_rvalid",  32'(bus.ldr_rvalid), 32'(m_pend == 2));
        chk("pipe_rdata",  32'(bus.pipe_rdata), 32'(e_prdata));
        chk("ldr_rdata",   32'(bus.ldr_rdata), 32'(e_lrdata));
        chk("ldr_locked",  32'(bus.ldr_locked), 32'(m_locked));
        @(posedge clk);
        m_phold = e_prdata;
        m_lhold = e_lrdata;
        m_pend  = 0;
        if ((pg || lg) && !e_we) begin
            m_pend      = pg ? 1 : 2;
            m_pend_data = shadow[e_addr];
        end
        if ((pg || lg) && e_we) shadow[e_addr] = e_wdata;
        if (m_locked)               m_starve = 0;
        else if (lreq && !lg)       m_starve = (m_starve < LIMIT) ? m_starve + 1 : m_starve;
        else                        m_starve = 0;
        m_locked = lock;
    endtask

    task automatic idle_cycle();
        cycle(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        bit lock_r;
        for (int i = 0; i < (1 << AW); i++) begin
            mem_arr[i] = '0;
            shadow[i]  = '0;
        end
        drive_idle();
        model_reset();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("idle");
        repeat (3) idle_cycle();

        // Pipeline priority over a simultaneous loader write
        cycle(1, 0, 13'h010, '0, 1, 1, 13'h020, 16'hBEEF, 0);
        cycle(0, 0, '0, '0, 1, 1, 13'h020, 16'hBEEF, 0);
        idle_cycle();

        // Starvation: loader forced through every STARVE_LIMIT+1 cycles
        for (int c = 0; c < 10; c++)
            cycle(1, 0, 13'(c), '0, 1, 0, 13'h020, '0, 0);
        idle_cycle();

        // Lock entered while a pipeline read is granted, held 20 cycles
        cycle(1, 0, 13'h005, '0, 0, 0, '0, '0, 1);
        for (int c = 1; c < 20; c++)
            cycle(1'($urandom_range(0, 1)), 0, 13'($urandom_range(0, 15)), '0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)),
                  16'($urandom), 1);
        cycle(1, 0, 13'h003, '0, 1, 0, 13'h004, '0, 0);
        cycle(1, 0, 13'h003, '0, 1, 0, 13'h004, '0, 0);
        idle_cycle();

        // Read routing with alternating owners
        cycle(0, 0, '0, '0, 1, 1, 13'h001, 16'h1111, 0);
        cycle(0, 0, '0, '0, 1, 1, 13'h002, 16'h2222, 0);
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) cycle(1, 0, 13'h001, '0, 0, 0, '0, '0, 0);
            else            cycle(0, 0, '0, '0, 1, 0, 13'h002, '0, 0);
        end
        repeat (2) idle_cycle();

        // Random traffic
        lock_r = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) lock_r = ~lock_r;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)),
                  16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  13'($urandom_range(0, 15)), 16'($urandom), lock_r);
        end
        repeat (2) idle_cycle();

        // Reset asserted in the cycle after a granted read
        cycle(1, 0, 13'h001, '0, 0, 0, '0, '0, 1);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrd");
        @(posedge clk);
        @(negedge clk);
        chk("midrd_prvalid2", 32'(bus.pipe_rvalid), 0);
        chk("midrd_lrvalid2", 32'(bus.ldr_rvalid), 0);
        rst = 1'b1;
        repeat (2) idle_cycle();
        cycle(1, 0, 13'h002, '0, 1, 0, 13'h001, '0, 0);
        repeat (2) idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (2^MEMORY_ADDR_SIZE x ARQ words) between two requesters.
  - The MEM pipeline stage.
  - The host/key loader, which uploads RSA keys and message blocks and reads back results.
- Sits between the MEM stage and the data memory instance.
- Resolves one access per cycle and stalls the pipeline when it loses arbitration.
- Provides a lock mode that gives the loader exclusive memory ownership during bulk uploads.

Parameters:
- ARQ, 16: data word width.
- MEMORY_ADDR_SIZE, 13: word address width.
- STARVE_LIMIT, 4: consecutive denied loader cycles before the loader is forced a grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- pipe_req  input  1  MEM stage requests an access this cycle.
- pipe_we  input  1  1 = write, 0 = read.
- pipe_addr  input  MEMORY_ADDR_SIZE  pipeline word address.
- pipe_wdata  input  ARQ  pipeline write data.
- pipe_stall  output  1  pipeline request not granted this cycle; freeze the pipeline.
- pipe_rvalid  output  1  pipeline read data valid this cycle.
- pipe_rdata  output  ARQ  pipeline read data.
- ldr_req  input  1  loader requests an access.
- ldr_we  input  1  1 = write, 0 = read.
- ldr_addr  input  MEMORY_ADDR_SIZE  loader word address.
- ldr_wdata  input  ARQ  loader write data.
- ldr_lock  input  1  loader requests exclusive ownership.
- ldr_gnt  output  1  loader access accepted this cycle.
- ldr_rvalid  output  1  loader read data valid this cycle.
- ldr_rdata  output  ARQ  loader read data.
- ldr_locked  output  1  arbiter is in LOCKED state.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  MEMORY_ADDR_SIZE  memory address.
- mem_wdata  output  ARQ  memory write data.
- mem_rdata  input  ARQ  memory read data, valid one cycle after a read strobe.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=SHARED, starve_cnt=0, rd_owner=NONE.
  - pipe_rvalid=0, ldr_rvalid=0, ldr_locked=0.
  - pipe_rdata and ldr_rdata hold registers = 0.
  - All combinational outputs evaluate to 0 while no requests are present.
  - Reset mid-read discards the in-flight read; no rvalid is issued for it after reset.
- Grant logic is combinational from current state and requests:
  - SHARED, normal case: the pipeline has priority. If pipe_req=1, the pipeline is granted unless the starvation rule below applies. If pipe_req=0 and ldr_req=1, the loader is granted.
  - SHARED, starvation rule: if ldr_req=1 and starve_cnt==STARVE_LIMIT, the loader is granted and pipe_stall=pipe_req.
  - LOCKED: only the loader can be granted (ldr_gnt=ldr_req); pipe_stall=pipe_req.
- Memory drive:
  - mem_en=1 iff one requester is granted.
  - mem_we, mem_addr and mem_wdata come from the granted requester.
  - mem_addr and mem_wdata are 0 when idle.
- pipe_stall = pipe_req AND NOT pipeline-granted. ldr_gnt = loader granted.
- starve_cnt:
  - Increments when ldr_req=1 and ldr_gnt=0; saturates at STARVE_LIMIT.
  - Clears to 0 when ldr_gnt=1 or ldr_req=0.
  - Held at 0 in LOCKED.
- Read return:
  - A granted read registers rd_owner (PIPE or LDR).
  - In the next cycle, exactly one of pipe_rvalid / ldr_rvalid is 1.
  - The owner's rdata output equals mem_rdata during the rvalid cycle, and the value is captured into the hold register.
  - Outside the rvalid cycle, each rdata output holds its last captured value.
  - Writes produce no rvalid.
- FSM transitions:
  - SHARED -> LOCKED on a clock edge where ldr_lock=1. The transition cycle arbitrates under SHARED rules, so a pipeline read granted in that cycle still returns its rvalid in the first LOCKED cycle.
  - LOCKED -> SHARED on a clock edge where ldr_lock=0. That cycle still arbitrates under LOCKED rules.
  - ldr_locked = (state==LOCKED).
- Simultaneous pipe_req and ldr_req with ldr_lock rising: SHARED priority applies in that cycle.
- Back-to-back reads from alternating owners: each rvalid is routed by the rd_owner registered for that access; no bubbles are required.
- No memory access is ever issued for both requesters in the same cycle.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst=0 for 2 cycles, release, no requests.
  - Required: all outputs 0, ldr_locked=0, mem_en=0.
- Pipeline priority:
  - Stimulus: pipe read at addr 0x010 and loader write at 0x020 of 0xBEEF, both in the same cycle.
  - Required: mem_addr=0x010 and ldr_gnt=0. The next cycle grants the loader write. pipe_rvalid=1 with pipe_rdata=mem_rdata one cycle after the pipe grant.
- Starvation:
  - Stimulus: pipe_req held for 10 cycles; ldr_req held from cycle 0.
  - Required: ldr_gnt=1 and pipe_stall=1 in cycle 4 (STARVE_LIMIT=4) and again in cycle 9. pipe_stall=0 in all other cycles.
- Lock:
  - Stimulus: ldr_lock=1 at cycle 0 while a pipe read to 0x005 is granted in cycle 0.
  - Required: pipe_rvalid=1 in cycle 1 and ldr_locked=1 from cycle 1. Pipe requests stall for the whole locked period. Deasserting ldr_lock at cycle 20 gives SHARED from cycle 21.
- Read routing:
  - Stimulus: alternating pipe and loader reads every cycle at addrs 0x001/0x002, with memory preloaded 0x1111/0x2222.
  - Required: pipe_rdata=0x1111 and ldr_rdata=0x2222, each on its own rvalid pulse; the rdata outputs hold those values between pulses.
- Reset mid-read:
  - Stimulus: assert rst in the cycle after a granted read.
  - Required: no rvalid is asserted afterwards; state=SHARED.
